// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Receive side of a multiplexed 7-segment scan bus ({seg7, one-hot line}).
//   Inputs pass through one sample register. Each digit slot must hold still
//   for a number of cycles before it is captured. Captured segment patterns
//   are decoded back to BCD. When all four slots have been captured, the
//   slots are published as one 16-bit frame.
//
//   Optional feature: define SEG7_DP_CAPTURE_EN to add the 4-bit dp output.
//   That output carries the decimal-point bit captured for each digit. The
//   DP bits also take part in the "changed" comparison. When the macro is
//   undefined, seg7[7] only takes part in change detection.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk0,
  input  logic        rst,
  input  logic [7:0]  seg7,
  input  logic [3:0]  line,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_stb,
  output logic        changed,
  output logic        seg_err,
  output logic        line_err
`ifdef SEG7_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [7:0]  seg_s;
  logic [3:0]  line_s;
  logic [11:0] prev;

  logic        chg;
  logic        one_hot;
  logic        multi;
  logic        prev_multi;
  logic [1:0]  slot;
  logic [3:0]  code;
  logic        code_ok;
  logic        cap;

  logic [15:0] shadow;
  logic [15:0] shadow_nx;
  logic [3:0]  seen;
  logic [3:0]  seen_nx;
  logic        pub_pend;

`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0]  dp_shadow;
  logic [3:0]  dp_shadow_nx;
`endif

  // Sample stage: one register on the bus, then one more copy for change detection.
  always_ff @(posedge clk0) begin
    if (rst) begin
      seg_s  <= 8'h00;
      line_s <= 4'h0;
      prev   <= 12'h000;
    end else begin
      seg_s  <= seg7;
      line_s <= line;
      prev   <= {seg_s, line_s};
    end
  end

  // Classify the sampled select lines and flag any movement on the bus.
  always_comb begin
    chg        = ({seg_s, line_s} != prev);
    one_hot    = (line_s != 4'h0) && ((line_s & (line_s - 4'd1)) == 4'h0);
    multi      = (line_s != 4'h0) && !one_hot;
    prev_multi = (prev[3:0] != 4'h0) && ((prev[3:0] & (prev[3:0] - 4'd1)) != 4'h0);
  end

  // Map the one-hot select to a digit index (only used while one-hot).
  always_comb begin
    slot = 2'd0;
    case (line_s)
      4'b0010: slot = 2'd1;
      4'b0100: slot = 2'd2;
      4'b1000: slot = 2'd3;
      default: slot = 2'd0;
    endcase
  end

  // Segment pattern back to BCD; all-off is a blanked digit (F), anything unknown is E.
  always_comb begin
    code    = 4'hE;
    code_ok = 1'b0;
    case (seg_s[6:0])
      7'h3F: begin code = 4'h0; code_ok = 1'b1; end
      7'h06: begin code = 4'h1; code_ok = 1'b1; end
      7'h5B: begin code = 4'h2; code_ok = 1'b1; end
      7'h4F: begin code = 4'h3; code_ok = 1'b1; end
      7'h66: begin code = 4'h4; code_ok = 1'b1; end
      7'h6D: begin code = 4'h5; code_ok = 1'b1; end
      7'h7D: begin code = 4'h6; code_ok = 1'b1; end
      7'h27: begin code = 4'h7; code_ok = 1'b1; end
      7'h7F: begin code = 4'h8; code_ok = 1'b1; end
      7'h6F: begin code = 4'h9; code_ok = 1'b1; end
      7'h00: begin code = 4'hF; code_ok = 1'b1; end
      default: begin code = 4'hE; code_ok = 1'b0; end
    endcase
  end

  // Capture happens on the terminal count of a settle that saw no movement.
  always_comb begin
    cap = (state == ST_SETTLE) && !chg && (cnt == CNT_LAST);
  end

  // Settle FSM: count quiet cycles per slot visit, capture once, then hold until the bus moves.
  always_ff @(posedge clk0) begin
    if (rst) begin
      state    <= ST_WAIT;
      cnt      <= '0;
      line_err <= 1'b0;
    end else begin
      line_err <= multi && !prev_multi;
      case (state)
        ST_WAIT: begin
          if (one_hot && chg) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (chg) begin
            cnt   <= '0;
            state <= one_hot ? ST_SETTLE : ST_WAIT;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (chg) begin
            cnt   <= '0;
            state <= one_hot ? ST_SETTLE : ST_WAIT;
          end
        end
        default: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Next shadow contents, so a capture landing in the publish cycle is part of that frame.
  always_comb begin
    shadow_nx = shadow;
    seen_nx   = seen;
    if (cap) begin
      shadow_nx[{slot, 2'b00} +: 4] = code;
      seen_nx[slot]                 = 1'b1;
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  // Decimal-point shadow follows the same capture as the digit shadow.
  always_comb begin
    dp_shadow_nx = dp_shadow;
    if (cap) begin
      dp_shadow_nx[slot] = seg_s[7];
    end
  end
`endif

  // Shadow/seen bookkeeping and frame publication one cycle after the last slot arrives.
  always_ff @(posedge clk0) begin
    if (rst) begin
      shadow      <= 16'h0000;
      seen        <= 4'h0;
      pub_pend    <= 1'b0;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      frame_stb   <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      dp_shadow   <= 4'h0;
      dp          <= 4'h0;
`endif
    end else begin
      frame_stb <= 1'b0;
      changed   <= 1'b0;
      seg_err   <= cap && !code_ok;
      shadow    <= shadow_nx;
`ifdef SEG7_DP_CAPTURE_EN
      dp_shadow <= dp_shadow_nx;
`endif
      if (pub_pend) begin
        digits      <= shadow_nx;
        frame_valid <= 1'b1;
        frame_stb   <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
        dp          <= dp_shadow_nx;
        changed     <= (shadow_nx != digits) || (dp_shadow_nx != dp) || !frame_valid;
`else
        changed     <= (shadow_nx != digits) || !frame_valid;
`endif
        seen        <= 4'h0;
        pub_pend    <= 1'b0;
      end else begin
        seen     <= seen_nx;
        pub_pend <= (seen_nx == 4'hF);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture
//   Directed bench for seg7_scan_capture with STABLE_CYCLES = 4.
//   A run-length model of the scan bus predicts every output. A compare
//   process checks the outputs against that model on each falling edge.
//   Literal expectations after each scenario pin the model itself.
//   Optional feature: define SEG7_DP_CAPTURE_EN to also check the dp output.
module tb_seg7_scan_capture;

  localparam int S = 4;
`ifdef SEG7_DP_CAPTURE_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic        clk0 = 1'b0;
  logic        rst;
  logic [7:0]  seg7;
  logic [3:0]  line;
  logic [15:0] digits;
  logic        frame_valid;
  logic        frame_stb;
  logic        changed;
  logic        seg_err;
  logic        line_err;
  logic [3:0]  dp;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int stb_cnt      = 0;
  int seg_err_cnt  = 0;
  int line_err_cnt = 0;
  logic last_changed = 1'b0;

  // Model state: expected outputs plus the run length of the bus value.
  logic [11:0] m_last;
  int          m_run;
  logic        m_cap_pend;
  logic [1:0]  m_cap_idx;
  logic [3:0]  m_cap_code;
  logic        m_cap_bad;
  logic        m_cap_dp;
  logic        m_pub_pend;
  logic        m_le_pend;
  logic        m_prev_multi;
  logic [15:0] m_shadow;
  logic [3:0]  m_seen;
  logic [3:0]  m_dp_shadow;
  logic [15:0] e_digits;
  logic        e_valid;
  logic        e_stb;
  logic        e_changed;
  logic        e_seg_err;
  logic        e_line_err;
  logic [3:0]  e_dp;

  logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

  // Free-running clock.
  always #5 clk0 = ~clk0;

  seg7_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk0        (clk0),
    .rst         (rst),
    .seg7        (seg7),
    .line        (line),
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_stb   (frame_stb),
    .changed     (changed),
    .seg_err     (seg_err),
    .line_err    (line_err)
`ifdef SEG7_DP_CAPTURE_EN
    ,
    .dp          (dp)
`endif
  );

`ifndef SEG7_DP_CAPTURE_EN
  assign dp = 4'h0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] modelDecode(input logic [6:0] p);
    logic [3:0] r;
    r = 4'hE;
    if (p == 7'h00) r = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (pat_tab[i] == p) r = 4'(i);
    end
    return r;
  endfunction

  // One clock edge of the model, using the bus value presented at that edge.
  task automatic stepModel();
    logic [11:0] v;
    int          ones;
    if (rst) begin
      m_last = 12'h000; m_run = 1;
      m_cap_pend = 1'b0; m_pub_pend = 1'b0; m_le_pend = 1'b0; m_prev_multi = 1'b0;
      m_shadow = 16'h0; m_seen = 4'h0; m_dp_shadow = 4'h0;
      e_digits = 16'h0; e_valid = 1'b0; e_stb = 1'b0; e_changed = 1'b0;
      e_seg_err = 1'b0; e_line_err = 1'b0; e_dp = 4'h0;
      m_cap_idx = 2'd0; m_cap_code = 4'h0; m_cap_bad = 1'b0; m_cap_dp = 1'b0;
      return;
    end
    e_stb = 1'b0;
    e_changed = 1'b0;
    e_seg_err = 1'b0;
    e_line_err = m_le_pend;
    if (m_cap_pend) begin
      m_shadow[m_cap_idx*4 +: 4] = m_cap_code;
      m_dp_shadow[m_cap_idx] = m_cap_dp;
      m_seen[m_cap_idx] = 1'b1;
      e_seg_err = m_cap_bad;
    end
    if (m_pub_pend) begin
      e_changed = (m_shadow != e_digits) || !e_valid || (DP_EN && (m_dp_shadow != e_dp));
      e_digits = m_shadow;
      e_dp = m_dp_shadow;
      e_valid = 1'b1;
      e_stb = 1'b1;
      m_seen = 4'h0;
      m_pub_pend = 1'b0;
    end else if (m_seen == 4'hF) begin
      m_pub_pend = 1'b1;
    end
    v = {seg7, line};
    if (v == m_last) m_run++;
    else begin
      m_last = v;
      m_run = 1;
    end
    ones = $countones(line);
    m_cap_pend = (ones == 1) && (m_run == S + 1);
    if (m_cap_pend) begin
      for (int k = 0; k < 4; k++) if (line[k]) m_cap_idx = 2'(k);
      m_cap_code = modelDecode(seg7[6:0]);
      m_cap_bad = (m_cap_code == 4'hE);
      m_cap_dp = seg7[7];
    end
    m_le_pend = (ones >= 2) && !m_prev_multi;
    m_prev_multi = (ones >= 2);
  endtask

  // Drive n cycles of one bus value at the falling edge, step the model at the rising edge.
  task automatic applyStimulus(input logic [7:0] s, input logic [3:0] l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      seg7 = s;
      line = l;
      rst  = r;
      @(posedge clk0);
      stepModel();
      @(negedge clk0);
    end
  endtask

  task automatic applyFrame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input int n);
    applyStimulus(s0, 4'b0001, 1'b0, n);
    applyStimulus(s1, 4'b0010, 1'b0, n);
    applyStimulus(s2, 4'b0100, 1'b0, n);
    applyStimulus(s3, 4'b1000, 1'b0, n);
    applyStimulus(8'h00, 4'b0000, 1'b0, 3);
  endtask

  // Compare process: DUT against model every cycle, plus pulse bookkeeping.
  always @(negedge clk0) begin
    if (cmp_en) begin
      checkOutput("digits", 32'(digits), 32'(e_digits));
      checkOutput("frame_valid", 32'(frame_valid), 32'(e_valid));
      checkOutput("frame_stb", 32'(frame_stb), 32'(e_stb));
      checkOutput("changed", 32'(changed), 32'(e_changed));
      checkOutput("seg_err", 32'(seg_err), 32'(e_seg_err));
      checkOutput("line_err", 32'(line_err), 32'(e_line_err));
      if (DP_EN) checkOutput("dp", 32'(dp), 32'(e_dp));
      if (frame_stb === 1'b1) begin
        stb_cnt++;
        last_changed = changed;
      end
      if (seg_err === 1'b1) seg_err_cnt++;
      if (line_err === 1'b1) line_err_cnt++;
    end
  end

  // Directed scenarios with hand-computed results.
  initial begin
    int b_stb, b_seg, b_line;
    rst = 1'b1; seg7 = 8'h00; line = 4'h0;
    @(negedge clk0);
    applyStimulus(8'h00, 4'h0, 1'b1, 2);
    cmp_en = 1'b1;
    checkOutput("reset_digits", 32'(digits), 32'h0);
    checkOutput("reset_valid", 32'(frame_valid), 32'h0);
    applyStimulus(8'h00, 4'h0, 1'b0, 2);

    $display("[TB] first frame 3210");
    b_stb = stb_cnt;
    applyFrame(8'h3F, 8'h06, 8'h5B, 8'h4F, 10);
    checkOutput("f1_stb_count", 32'(stb_cnt - b_stb), 32'd1);
    checkOutput("f1_digits", 32'(digits), 32'h3210);
    checkOutput("f1_valid", 32'(frame_valid), 32'h1);
    checkOutput("f1_changed", 32'(last_changed), 32'h1);

    $display("[TB] repeated frame unchanged");
    b_stb = stb_cnt;
    applyFrame(8'h3F, 8'h06, 8'h5B, 8'h4F, 10);
    checkOutput("f2_stb_count", 32'(stb_cnt - b_stb), 32'd1);
    checkOutput("f2_changed", 32'(last_changed), 32'h0);
    checkOutput("f2_digits", 32'(digits), 32'h3210);

    $display("[TB] short glitch before settle");
    b_stb = stb_cnt;
    applyStimulus(8'h3F, 4'b0001, 1'b0, 3);
    applyFrame(8'h06, 8'h06, 8'h5B, 8'h4F, 10);
    checkOutput("f3_stb_count", 32'(stb_cnt - b_stb), 32'd1);
    checkOutput("f3_digits", 32'(digits), 32'h3211);
    checkOutput("f3_changed", 32'(last_changed), 32'h1);

    $display("[TB] undecodable pattern");
    b_seg = seg_err_cnt;
    applyFrame(8'h01, 8'h06, 8'h5B, 8'h4F, 10);
    checkOutput("f4_seg_err_count", 32'(seg_err_cnt - b_seg), 32'd1);
    checkOutput("f4_digits", 32'(digits), 32'h321E);

    $display("[TB] multi-hot and blank lines");
    b_stb = stb_cnt; b_seg = seg_err_cnt; b_line = line_err_cnt;
    applyStimulus(8'h3F, 4'b0011, 1'b0, 10);
    checkOutput("f5_line_err_count", 32'(line_err_cnt - b_line), 32'd1);
    applyStimulus(8'h3F, 4'b0000, 1'b0, 10);
    checkOutput("f5_line_err_after_blank", 32'(line_err_cnt - b_line), 32'd1);
    checkOutput("f5_seg_err_count", 32'(seg_err_cnt - b_seg), 32'd0);
    checkOutput("f5_stb_count", 32'(stb_cnt - b_stb), 32'd0);
    checkOutput("f5_digits", 32'(digits), 32'h321E);

    $display("[TB] reset during settle");
    applyStimulus(8'h3F, 4'b0001, 1'b0, 3);
    applyStimulus(8'h3F, 4'b0001, 1'b1, 1);
    checkOutput("f6_reset_digits", 32'(digits), 32'h0);
    checkOutput("f6_reset_valid", 32'(frame_valid), 32'h0);
    b_stb = stb_cnt;
    applyFrame(8'h3F, 8'h06, 8'h5B, 8'h4F, 10);
    checkOutput("f6_stb_count", 32'(stb_cnt - b_stb), 32'd1);
    checkOutput("f6_digits", 32'(digits), 32'h3210);
    checkOutput("f6_changed", 32'(last_changed), 32'h1);

    $display("[TB] minimum settle and blank digit");
    b_stb = stb_cnt;
    applyStimulus(8'h7F, 4'b0001, 1'b0, S + 1);
    applyStimulus(8'h6D, 4'b0010, 1'b0, S);
    applyStimulus(8'h00, 4'b0000, 1'b0, 2);
    applyFrame(8'h7F, 8'h66, 8'h00, 8'h27, S + 1);
    checkOutput("f7_stb_count", 32'(stb_cnt - b_stb), 32'd1);
    checkOutput("f7_digits", 32'(digits), 32'h7F48);

    $display("[TB] decimal point on digit 2");
    applyFrame(8'h3F, 8'h06, 8'hDB, 8'h4F, 10);
    checkOutput("f8_digits", 32'(digits), 32'h3210);
`ifdef SEG7_DP_CAPTURE_EN
    checkOutput("f8_dp", 32'(dp), 32'h4);
`endif
    checkOutput("f8_changed", 32'(last_changed), 32'h1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
